// File: rtl/bet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bet_pkg                                                   |
// | Purpose  : Shared types and helpers for the multi-seat bet settler.  |
// |            side_t    - wager side encoding (matches bet_side bits)   |
// |            state_t   - round state machine encoding                  |
// |            outcome_t - result of the player/dealer score compare     |
// |            sat_add   - unsigned add clamped to a caller-given max    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package bet_pkg;

   typedef enum logic [1:0] {
      SIDE_NONE   = 2'b00,
      SIDE_PLAYER = 2'b01,
      SIDE_DEALER = 2'b10,
      SIDE_TIE    = 2'b11
   } side_t;

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      LOCKED = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      P_WIN = 2'd0,
      D_WIN = 2'd1,
      TIE   = 2'd2
   } outcome_t;

   // 33-bit intermediate so the carry out of the 32-bit add is visible
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_val})
         sat_add = max_val;
      else
         sat_add = sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seat_payout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seat_payout                                               |
// | Purpose  : Combinational settlement of one seat's wager.             |
// | Ports    : old_bal  in  BAL_W  balance before settlement             |
// |            amt      in  BET_W  wagered amount                        |
// |            side     in  side_t wagered side                          |
// |            outcome  in  outcome_t round result                       |
// |            new_bal  out BAL_W  balance after settlement              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seat_payout
   import bet_pkg::*;
#(
   parameter int BAL_W      = 10,
   parameter int BET_W      = 4,
   parameter int TIE_PAYOUT = 8
) (
   input  logic [BAL_W-1:0] old_bal,
   input  logic [BET_W-1:0] amt,
   input  side_t            side,
   input  outcome_t         outcome,
   output logic [BAL_W-1:0] new_bal
);

   localparam logic [31:0] BAL_MAX = {{(32-BAL_W){1'b0}}, {BAL_W{1'b1}}};

   logic [BET_W+3:0] tie_win;
   logic [31:0]      old32;
   logic [31:0]      delta32;
   logic [31:0]      res32;
   logic             win;
   logic             lose;

   // Tie payout product is formed at BET_W+4 bits; a 4-bit multiplier fits
   assign tie_win = {4'b0000, amt} * (BET_W+4)'(TIE_PAYOUT);
   assign old32   = {{(32-BAL_W){1'b0}}, old_bal};

   always_comb begin
      win     = 1'b0;
      lose    = 1'b0;
      delta32 = {{(32-BET_W){1'b0}}, amt};
      unique case (side)
         SIDE_PLAYER: begin
            win  = (outcome == P_WIN);
            lose = (outcome == D_WIN);
         end
         SIDE_DEALER: begin
            win  = (outcome == D_WIN);
            lose = (outcome == P_WIN);
         end
         SIDE_TIE: begin
            if (outcome == TIE) begin
               win     = 1'b1;
               delta32 = {{(32-BET_W-4){1'b0}}, tie_win};
            end else begin
               lose = 1'b1;
            end
         end
         default: ;
      endcase

      if (win)
         res32 = sat_add(old32, delta32, BAL_MAX);
      else if (lose)
         // Acceptance guarantees amt<=balance; the clamp is a safety net
         res32 = (old32 >= delta32) ? (old32 - delta32) : 32'd0;
      else
         res32 = old32;

      new_bal = res32[BAL_W-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/bet_settler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bet_settler                                               |
// | Purpose  : Multi-seat baccarat wager ledger. Takes one bet per seat  |
// |            while open, locks on round start, and on endround settles |
// |            seats one per clock through a shared payout unit.         |
// | Ports    : slow_clock, resetb (async active-low)                     |
// |            lock, endround, pscore[3:0], dscore[3:0]                  |
// |            bet_valid[SEATS], bet_amt[SEATS*BET_W], bet_side[SEATS*2] |
// |            balance[SEATS*BAL_W], bet_err[SEATS], broke[SEATS]        |
// |            round_open, settle_done                                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bet_settler
   import bet_pkg::*;
#(
   parameter int SEATS      = 2,
   parameter int BAL_W      = 10,
   parameter int BET_W      = 4,
   parameter int START_BAL  = 100,
   parameter int TIE_PAYOUT = 8
) (
   input  logic                   slow_clock,
   input  logic                   resetb,
   input  logic                   lock,
   input  logic                   endround,
   input  logic [3:0]             pscore,
   input  logic [3:0]             dscore,
   input  logic [SEATS-1:0]       bet_valid,
   input  logic [SEATS*BET_W-1:0] bet_amt,
   input  logic [SEATS*2-1:0]     bet_side,
   output logic [SEATS*BAL_W-1:0] balance,
   output logic [SEATS-1:0]       bet_err,
   output logic [SEATS-1:0]       broke,
   output logic                   round_open,
   output logic                   settle_done
);

   localparam int IDX_W = (SEATS > 1) ? $clog2(SEATS) : 1;

   state_t           state;
   state_t           state_nxt;
   outcome_t         outcome_q;
   outcome_t         outcome_now;
   logic [IDX_W-1:0] idx_q;

   logic [BAL_W-1:0] bal_q    [SEATS];
   logic [BET_W-1:0] amt_q    [SEATS];
   side_t            side_q   [SEATS];
   logic [BET_W-1:0] amt_in   [SEATS];
   side_t            side_in  [SEATS];
   logic [SEATS-1:0] accept;
   logic [SEATS-1:0] err_q;
   logic [BAL_W-1:0] payout_bal;

   generate
      for (genvar i = 0; i < SEATS; i++) begin : g_seat
         assign amt_in[i]  = bet_amt[i*BET_W +: BET_W];
         assign side_in[i] = side_t'(bet_side[i*2 +: 2]);
         assign accept[i]  = bet_valid[i] && (side_in[i] != SIDE_NONE) &&
                             (amt_in[i] != '0) &&
                             ({{(32-BET_W){1'b0}}, amt_in[i]} <=
                              {{(32-BAL_W){1'b0}}, bal_q[i]});
         assign balance[i*BAL_W +: BAL_W] = bal_q[i];
         assign broke[i] = (bal_q[i] == '0);
      end
   endgenerate

   assign bet_err     = err_q;
   assign outcome_now = (pscore > dscore) ? P_WIN :
                        (pscore < dscore) ? D_WIN : TIE;

   // Single payout unit shared by all seats, steered by the settle index
   seat_payout #(
      .BAL_W      (BAL_W),
      .BET_W      (BET_W),
      .TIE_PAYOUT (TIE_PAYOUT)
   ) u_payout (
      .old_bal (bal_q[idx_q]),
      .amt     (amt_q[idx_q]),
      .side    (side_q[idx_q]),
      .outcome (outcome_q),
      .new_bal (payout_bal)
   );

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         state <= OPEN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      round_open = 1'b0;
      unique case (state)
         OPEN: begin
            round_open = 1'b1;
            if (lock)
               state_nxt = LOCKED;
         end
         LOCKED: begin
            if (endround)
               state_nxt = SETTLE;
         end
         SETTLE: begin
            if (idx_q == IDX_W'(SEATS-1))
               state_nxt = DONE;
         end
         DONE:    state_nxt = OPEN;
         default: state_nxt = OPEN;
      endcase
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < SEATS; i++) begin
            bal_q[i]  <= BAL_W'(START_BAL);
            amt_q[i]  <= '0;
            side_q[i] <= SIDE_NONE;
         end
         err_q       <= '0;
         outcome_q   <= P_WIN;
         idx_q       <= '0;
         settle_done <= 1'b0;
      end else begin
         err_q       <= '0;
         // Pulse lands in the cycle after DONE, while already back in OPEN
         settle_done <= (state == DONE);
         unique case (state)
            OPEN: begin
               for (int i = 0; i < SEATS; i++) begin
                  if (accept[i]) begin
                     amt_q[i]  <= amt_in[i];
                     side_q[i] <= side_in[i];
                  end else if (bet_valid[i]) begin
                     err_q[i] <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (endround) begin
                  outcome_q <= outcome_now;
                  idx_q     <= '0;
               end
            end
            SETTLE: begin
               bal_q[idx_q]  <= payout_bal;
               amt_q[idx_q]  <= '0;
               side_q[idx_q] <= SIDE_NONE;
               idx_q         <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bet_settler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bet_settler                                            |
// | Purpose  : Self-checking bench for bet_settler. Two instances share  |
// |            stimulus: A uses defaults, B uses BAL_W=8/START_BAL=250.  |
// |            A behavioural ledger model predicts both every cycle.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_bet_settler;

   localparam int MAXV  [2] = '{1023, 255};
   localparam int START [2] = '{100, 250};
   localparam int TIEM      = 8;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       lock = 1'b0;
   logic       endround = 1'b0;
   logic [3:0] ps = 4'd0;
   logic [3:0] ds = 4'd0;
   logic [1:0] valid = 2'b00;
   logic [7:0] amt = 8'd0;
   logic [3:0] side = 4'd0;

   logic [19:0] bal_a;
   logic [15:0] bal_b;
   logic [1:0]  err_a, err_b, broke_a, broke_b;
   logic        open_a, open_b, done_a, done_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bet_settler u_dut_a (
      .slow_clock(clk), .resetb(resetb), .lock(lock), .endround(endround),
      .pscore(ps), .dscore(ds), .bet_valid(valid), .bet_amt(amt),
      .bet_side(side), .balance(bal_a), .bet_err(err_a), .broke(broke_a),
      .round_open(open_a), .settle_done(done_a)
   );

   bet_settler #(.SEATS(2), .BAL_W(8), .BET_W(4), .START_BAL(250),
                 .TIE_PAYOUT(8)) u_dut_b (
      .slow_clock(clk), .resetb(resetb), .lock(lock), .endround(endround),
      .pscore(ps), .dscore(ds), .bet_valid(valid), .bet_amt(amt),
      .bet_side(side), .balance(bal_b), .bet_err(err_b), .broke(broke_b),
      .round_open(open_b), .settle_done(done_b)
   );

   // ---------------- reference model: a ledger per configuration ----------
   int m_bal [2][2];
   int m_amt [2][2];
   int m_side[2][2];
   int m_err [2][2];
   int m_phase;      // 0 betting, 1 waiting for result, 2 paying, 3 wrap-up
   int m_k;          // next seat to pay
   int m_out;        // +1 player won, -1 dealer won, 0 tie
   int m_done;

   function automatic int settle(int b, int a, int sd, int o, int mx);
      int r;
      if (sd == 0)      r = b;
      else if (sd == 3) r = (o == 0) ? b + a * TIEM : b - a;
      else if (o == 0)  r = b;
      else if ((sd == 1 && o > 0) || (sd == 2 && o < 0)) r = b + a;
      else              r = b - a;
      return (r > mx) ? mx : r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 2; s++) begin
            m_bal[c][s] = START[c]; m_amt[c][s] = 0;
            m_side[c][s] = 0;       m_err[c][s] = 0;
         end
      m_phase = 0; m_k = 0; m_out = 0; m_done = 0;
   endtask

   task automatic model_step();
      int nd;
      int a, sd;
      nd = (m_phase == 3) ? 1 : 0;
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 2; s++) m_err[c][s] = 0;
      case (m_phase)
         0: begin
            for (int c = 0; c < 2; c++)
               for (int s = 0; s < 2; s++)
                  if (valid[s]) begin
                     a  = int'(amt[s*4 +: 4]);
                     sd = int'(side[s*2 +: 2]);
                     if (sd != 0 && a != 0 && a <= m_bal[c][s]) begin
                        m_amt[c][s] = a; m_side[c][s] = sd;
                     end else m_err[c][s] = 1;
                  end
            if (lock) m_phase = 1;
         end
         1: if (endround) begin
            m_out   = (ps > ds) ? 1 : (ps < ds) ? -1 : 0;
            m_phase = 2; m_k = 0;
         end
         2: begin
            for (int c = 0; c < 2; c++) begin
               m_bal[c][m_k] = settle(m_bal[c][m_k], m_amt[c][m_k],
                                      m_side[c][m_k], m_out, MAXV[c]);
               m_amt[c][m_k] = 0; m_side[c][m_k] = 0;
            end
            m_k++;
            if (m_k == 2) m_phase = 3;
         end
         default: m_phase = 0;
      endcase
      m_done = nd;
   endtask

   always @(posedge clk or negedge resetb) begin
      if (!resetb) model_reset();
      else         model_step();
   end

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("bal_a[%0d]", s), 32'(bal_a[s*10 +: 10]), 32'(m_bal[0][s]));
         chk($sformatf("bal_b[%0d]", s), 32'(bal_b[s*8 +: 8]),   32'(m_bal[1][s]));
         chk($sformatf("err_a[%0d]", s), 32'(err_a[s]), 32'(m_err[0][s]));
         chk($sformatf("err_b[%0d]", s), 32'(err_b[s]), 32'(m_err[1][s]));
         chk($sformatf("broke_a[%0d]", s), 32'(broke_a[s]), 32'(m_bal[0][s] == 0));
         chk($sformatf("broke_b[%0d]", s), 32'(broke_b[s]), 32'(m_bal[1][s] == 0));
      end
      chk("round_open_a", 32'(open_a), 32'(m_phase == 0));
      chk("round_open_b", 32'(open_b), 32'(m_phase == 0));
      chk("settle_done_a", 32'(done_a), 32'(m_done));
      chk("settle_done_b", 32'(done_b), 32'(m_done));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      check_all();
   endtask

   task automatic do_reset();
      resetb = 1'b0; lock = 1'b0; endround = 1'b0; valid = 2'b00;
      tick();
      resetb = 1'b1;
   endtask

   task automatic place(int a0, int s0, int a1, int s1, logic [1:0] v);
      valid = v;
      amt   = {4'(a1), 4'(a0)};
      side  = {2'(s1), 2'(s0)};
   endtask

   task automatic run_round(int p, int d);
      valid = 2'b00; lock = 1'b1; tick();
      lock = 1'b0; ps = 4'(p); ds = 4'(d); endround = 1'b1; tick();
      endround = 1'b0; tick(); tick(); tick();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int a0, s0, a1, s1, p, d;
      int ea0, ea1, eb0, eb1;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{5, 1, 7, 2, 8, 3,    105,  93, 255, 243};
      vt[1] = '{4, 3, 9, 1, 6, 6,    132, 100, 255, 250};
      vt[2] = '{9, 2, 3, 3, 2, 7,    109,  97, 255, 247};
      vt[3] = '{15, 3, 1, 2, 12, 12, 220, 100, 255, 250};
      vt[4] = '{0, 1, 5, 0, 4, 1,    100, 100, 250, 250};
      vt[5] = '{15, 1, 15, 2, 15, 0, 115,  85, 255, 235};

      model_reset();
      #3;
      do_reset();
      // reset state
      chk("rst_bal0", 32'(bal_a[9:0]),   32'd100);
      chk("rst_bal1", 32'(bal_a[19:10]), 32'd100);
      chk("rst_open", 32'(open_a), 32'd1);
      chk("rst_broke", 32'(broke_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         place(vt[i].a0, vt[i].s0, vt[i].a1, vt[i].s1, 2'b11);
         tick();
         valid = 2'b00; lock = 1'b1; tick();
         lock = 1'b0; ps = 4'(vt[i].p); ds = 4'(vt[i].d); endround = 1'b1;
         tick();
         endround = 1'b0;
         tick(); tick();
         chk($sformatf("v%0d_done_early", i), 32'(done_a), 32'd0);
         tick();
         chk($sformatf("v%0d_done", i), 32'(done_a), 32'd1);
         chk($sformatf("v%0d_a0", i), 32'(bal_a[9:0]),   32'(vt[i].ea0));
         chk($sformatf("v%0d_a1", i), 32'(bal_a[19:10]), 32'(vt[i].ea1));
         chk($sformatf("v%0d_b0", i), 32'(bal_b[7:0]),   32'(vt[i].eb0));
         chk($sformatf("v%0d_b1", i), 32'(bal_b[15:8]),  32'(vt[i].eb1));
      end

      // rejected bets: zero amount, then no side, then a bet after lock
      do_reset();
      place(0, 1, 0, 0, 2'b01); tick();
      chk("err_zero_amt", 32'(err_a), 32'd1);
      place(3, 0, 0, 0, 2'b01); tick();
      chk("err_no_side", 32'(err_a), 32'd1);
      valid = 2'b00; lock = 1'b1; tick();
      lock = 1'b0; place(3, 1, 3, 1, 2'b11); tick();
      chk("err_locked", 32'(err_a), 32'd0);
      valid = 2'b00; ps = 4'd5; ds = 4'd1; endround = 1'b1; tick();
      endround = 1'b0; tick(); tick(); tick();
      chk("rej_bal0", 32'(bal_a[9:0]),   32'd100);
      chk("rej_bal1", 32'(bal_a[19:10]), 32'd100);

      // saturation then drain to broke on the narrow instance
      do_reset();
      place(15, 3, 0, 0, 2'b01); tick();
      run_round(4, 4);
      chk("sat_b0", 32'(bal_b[7:0]), 32'd255);
      for (int r = 0; r < 17; r++) begin
         place(15, 1, 0, 0, 2'b01); tick();
         run_round(0, 9);
      end
      chk("drain_b0", 32'(bal_b[7:0]), 32'd0);
      chk("broke_b0", 32'(broke_b[0]), 32'd1);
      place(1, 1, 0, 0, 2'b01); tick();
      chk("broke_err_b0", 32'(err_b[0]), 32'd1);
      valid = 2'b00;

      // endround held through DONE/OPEN must not resettle
      do_reset();
      place(5, 1, 7, 2, 2'b11); tick();
      valid = 2'b00; lock = 1'b1; tick();
      lock = 1'b0; ps = 4'd8; ds = 4'd3; endround = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      endround = 1'b0;
      chk("hold_a0", 32'(bal_a[9:0]),   32'd105);
      chk("hold_a1", 32'(bal_a[19:10]), 32'd93);

      // bet and lock together, then reset after first seat is paid
      do_reset();
      place(5, 1, 7, 2, 2'b11); lock = 1'b1; tick();
      valid = 2'b00; lock = 1'b0; ps = 4'd8; ds = 4'd3; endround = 1'b1; tick();
      endround = 1'b0; tick();
      chk("mid_a0", 32'(bal_a[9:0]), 32'd105);
      resetb = 1'b0; #1;
      check_all();
      chk("mid_rst_a0", 32'(bal_a[9:0]), 32'd100);
      chk("mid_rst_open", 32'(open_a), 32'd1);
      tick(); resetb = 1'b1; tick(); tick();
      chk("mid_rst_nodone", 32'(done_a), 32'd0);

      // randomized traffic checked cycle-by-cycle against the model
      do_reset();
      for (int n = 0; n < 500; n++) begin
         valid    = 2'($urandom);
         amt      = 8'($urandom);
         side     = 4'($urandom);
         lock     = ($urandom_range(0, 5) == 0);
         endround = ($urandom_range(0, 3) == 0);
         ps       = 4'($urandom_range(0, 15));
         ds       = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 150) == 0) resetb = 1'b0;
         tick();
         resetb = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bet_settler.md
Name: bet_settler

Overview:
Parametrised successor to the single-player balance tracker. It holds a wager ledger for SEATS seats, accepts one bet per seat while betting is open, and locks the bets when the round starts. At endround it samples the final scores once and settles the seats sequentially, one per clock, using baccarat odds. It sits beside the statemachine/datapath pair and reads pscore/dscore directly.

Parameters:
SEATS, 2, number of independent betting seats (1..8)
BAL_W, 10, balance width per seat; balances saturate at 2^BAL_W-1
BET_W, 4, bet amount width per seat
START_BAL, 100, balance loaded into every seat at reset; must be < 2^BAL_W
TIE_PAYOUT, 8, multiplier for a winning tie bet (0..15)

Ports:
slow_clock  input  1  single clock for all state (KEY[0] domain)
resetb  input  1  reset, asynchronous and active-low
lock  input  1  round start; closes betting
endround  input  1  round finished; scores are final
pscore  input  4  player score, 0..9
dscore  input  4  dealer score, 0..9
bet_valid  input  SEATS  per-seat bet strobe
bet_amt  input  SEATS*BET_W  per-seat amount; seat i uses bits [i*BET_W +: BET_W]
bet_side  input  SEATS*2  per-seat side: 00 none, 01 player, 10 dealer, 11 tie
balance  output  SEATS*BAL_W  registered per-seat balances
bet_err  output  SEATS  one-cycle pulse when seat i's bet is rejected
broke  output  SEATS  balance[i]==0
round_open  output  1  high in OPEN
settle_done  output  1  one-cycle pulse when settlement completes

Behaviour:
- Reset (async, resetb=0): every balance = START_BAL; all bets cleared; state OPEN; bet_err=0; settle_done=0; seat index = 0.
- States: OPEN -> LOCKED -> SETTLE -> DONE -> OPEN.
- OPEN, with round_open=1:
  - A seat's bet is accepted when bet_valid[i]=1, side!=00, amt!=0 and amt<=balance[i]. The bet is latched on the next edge.
  - A later valid bet overwrites the earlier one. Balances are not deducted until settlement.
  - A bet that fails any condition is ignored, and bet_err[i] pulses for the following cycle.
  - lock=1 moves to LOCKED. If lock and bet_valid occur in the same cycle, the bet is still evaluated and latched.
  - endround is ignored in OPEN. If lock and endround are both high, lock wins.
- LOCKED: bet_valid is ignored and bet_err stays 0. endround=1 registers pscore/dscore, computes outcome (P>D player, P<D dealer, equal tie) and moves to SETTLE with index 0.
- SETTLE: seat[index] is updated each cycle, then index increments. After index SEATS-1 the state moves to DONE.
  - Player/dealer bet on the winning side: +amt.
  - Player/dealer bet on the losing side: -amt. amt<=balance is guaranteed, so there is no underflow.
  - Player/dealer bet with a tie outcome: push, no change.
  - Tie bet with a tie outcome: +amt*TIE_PAYOUT, computed at width BET_W+4.
  - Tie bet otherwise: -amt.
  - Side 00 or no bet: no change.
  - Every addition saturates at 2^BAL_W-1. The seat's bet is cleared after its update.
- DONE: settle_done=1 for exactly one cycle, then OPEN.
- Latency: endround sampled on edge E; seat i is updated on edge E+1+i; settle_done is high during the cycle after edge E+SEATS+1.
- endround held high across DONE/OPEN causes no resettle; a new lock is required.
- lock during LOCKED, SETTLE or DONE is ignored.
- Scores above 9 are compared as unsigned values with no error.
- Reset asserted mid-SETTLE: immediate return to the reset values. Partially updated balances are discarded and settle_done does not pulse.
- broke is combinational from the balance registers. A broke seat can only receive bet_err.

Decomposition:
- Package bet_pkg: side_t (NONE, PLAYER, DEALER, TIE), state_t (OPEN, LOCKED, SETTLE, DONE), outcome_t (P_WIN, D_WIN, TIE), and a sat_add function.
- Sub-module seat_payout (combinational): inputs old balance, amt, side, outcome; output new balance. It is instantiated once and muxed by index.

Test Plan:
1. Reset, SEATS=2 -> balance = {100,100}, round_open=1, broke=0, settle_done=0.
2. Seat0 bets 5 PLAYER, seat1 bets 7 DEALER, lock, endround with pscore=8 dscore=3 -> settle_done pulses 3 edges after endround sample; balances {105,93}.
3. From reset: seat0 bets 4 TIE, seat1 bets 9 PLAYER, pscore=dscore=6 -> balances {132,100}.
4. bet_amt=0, then side=00, then a bet after lock -> bet_err pulses for the first two only; no bets latched; balances unchanged after settlement.
5. BAL_W=8, START_BAL=250, seat0 bets 15 TIE on a tie -> balance saturates at 255. Next round, lose with 15 repeatedly until 0 -> broke[0]=1, and a bet of 1 gives bet_err[0].
6. Assert resetb during SETTLE after seat0 is updated -> balances {100,100}, state OPEN, no settle_done pulse.
